// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_pkg
// Description : Shared bus command encoding, tag-table entry layout and
//               sizing constants for the multi-channel memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_req_arbiter_pkg;

    // Default processor address width.
    localparam int XLEN       = 32;

    // Memory tag width; tag 0 is reserved for "no tag / rejected".
    localparam int MEM_TAG_W  = 4;

    // Largest supported channel count, which sizes the owner field.
    localparam int NUM_CH_MAX = 8;
    localparam int OWNER_W    = $clog2(NUM_CH_MAX);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    // One tag-table slot: whether a load is in flight on this tag, and
    // which channel issued it.
    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } mem_tag_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin / fixed-priority single-grant arbiter. Grant is
//               combinational from the request vector; the rotation pointer
//               only moves when the caller strobes advance.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_CH     = 2,
    parameter  int FIXED_PRIO = 0,
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    localparam logic [IDX_W:0]   c_num_ch = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0] c_last   = IDX_W'(NUM_CH - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W:0]   w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Fixed priority always scans from channel 0; round-robin from the pointer.
    assign w_base = (FIXED_PRIO != 0) ? '0 : r_ptr;

    // Scan upward from the base index, wrapping, and take the first requester.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = {1'b0, w_base} + (IDX_W+1)'(i);
            if (w_cand >= c_num_ch) begin
                w_cand = w_cand - c_num_ch;
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    // Expand the winning index to a one-hot grant vector.
    always_comb begin
        grant = '0;
        if (w_found) begin
            grant[w_idx] = 1'b1;
        end
    end

    assign grant_idx   = w_idx;
    assign grant_valid = w_found;

    // Move the pointer just past the winner only when its request was taken,
    // so a rejected winner keeps its turn.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            if (w_idx == c_last) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Arbitrates NUM_CH cache-side requesters onto the single memory
//               port and routes each returning load tag back to the channel
//               that issued it, using a tag-indexed ownership table.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = MEM_TAG_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0][1:0]       ch2ctrl_command,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] ch2ctrl_addr,
    input  logic [NUM_CH-1:0][DATA_W-1:0] ch2ctrl_data,
    output logic [NUM_CH-1:0][TAG_W-1:0] ctrl2ch_response,
    output logic [DATA_W-1:0]            ctrl2ch_data,
    output logic [NUM_CH-1:0][TAG_W-1:0] ctrl2ch_tag,
    output logic [1:0]                   proc2mem_command,
    output logic [ADDR_W-1:0]            proc2mem_addr,
    output logic [DATA_W-1:0]            proc2mem_data,
    input  logic [TAG_W-1:0]             mem2proc_response,
    input  logic [DATA_W-1:0]            mem2proc_data,
    input  logic [TAG_W-1:0]             mem2proc_tag,
    output logic [TAG_W:0]               outstanding_cnt,
    output logic                         stray_tag
);

    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_depth = 2 ** TAG_W;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_grant;
    logic [IDX_W-1:0]  w_gidx;
    logic              w_gany;
    logic              w_gvalid;
    logic [1:0]        w_gcmd;
    logic              w_accept;
    logic              w_alloc;
    logic              w_retire;
    logic              w_same_tag;
    logic              w_cnt_inc;

    mem_tag_entry_t    r_table [c_depth];
    mem_tag_entry_t    w_ret_entry;
    mem_tag_entry_t    w_alloc_entry;
    logic [TAG_W:0]    r_cnt;
    logic              r_stray;

    rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (w_req),
        .advance     (w_accept),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_gany)
    );

    // Grant is suppressed while reset is asserted so nothing reaches memory.
    assign w_gvalid = w_gany & reset_n;
    assign w_gcmd   = ch2ctrl_command[w_gidx];

    assign proc2mem_command = w_gvalid ? w_gcmd               : 2'(BUS_NONE);
    assign proc2mem_addr    = w_gvalid ? ch2ctrl_addr[w_gidx] : '0;
    assign proc2mem_data    = w_gvalid ? ch2ctrl_data[w_gidx] : '0;

    assign ctrl2ch_data = reset_n ? mem2proc_data : '0;

    // Return-side lookup: a nonzero tag with a live entry retires it.
    assign w_ret_entry = r_table[mem2proc_tag];
    assign w_retire    = reset_n && (mem2proc_tag != '0) && w_ret_entry.valid;

    // Request-side acceptance; only loads occupy a table slot.
    assign w_accept      = w_gvalid && (mem2proc_response != '0);
    assign w_alloc       = w_accept && (w_gcmd == 2'(BUS_LOAD));
    assign w_alloc_entry = r_table[mem2proc_response];
    assign w_same_tag    = w_retire && (mem2proc_tag == mem2proc_response);

    // The valid count grows only when the allocation lands in a slot that will
    // be empty at the edge; overwriting a live slot leaves the count alone.
    assign w_cnt_inc = w_alloc && (!w_alloc_entry.valid || w_same_tag);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_req[i]            = (ch2ctrl_command[i] != 2'(BUS_NONE));
        assign ctrl2ch_response[i] = (w_gvalid && w_grant[i]) ? mem2proc_response : '0;
        assign ctrl2ch_tag[i]      = (w_retire && (w_ret_entry.owner == OWNER_W'(i)))
                                     ? mem2proc_tag : '0;
    end

    // Tag table: retire clears, allocate writes afterwards so it wins a same-tag clash.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (w_retire) begin
                r_table[mem2proc_tag].valid <= 1'b0;
            end
            if (w_alloc) begin
                r_table[mem2proc_response] <= {1'b1, OWNER_W'(w_gidx)};
            end
        end
    end

    // Track the number of live table entries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && !w_retire) begin
            r_cnt <= r_cnt + (TAG_W+1)'(1);
        end else if (!w_cnt_inc && w_retire) begin
            r_cnt <= r_cnt - (TAG_W+1)'(1);
        end
    end

    // Flag a returning tag that nobody is waiting for.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stray <= 1'b0;
        end else begin
            r_stray <= (mem2proc_tag != '0) && !w_ret_entry.valid;
        end
    end

    assign outstanding_cnt = r_cnt;
    assign stray_tag       = r_stray;

    // Memory must not hand out a tag that is still in flight, unless that
    // tag is retiring in the same cycle.
    a_no_live_tag_reuse : assert property (@(posedge clock) disable iff (!reset_n)
        !(w_alloc && w_alloc_entry.valid && !w_same_tag));

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised successor to the two-port I/D cache_controller: arbitrates NUM_CH cache-side requesters (icache, dcache, prefetcher, ...) onto the single `mem` port.
- Tracks outstanding load tags in a tag table, so each returned mem2proc_tag is routed only to the channel that issued it.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- Sits between the caches and `mem`.

Parameters:
- NUM_CH, 2, number of requester channels (2..8); channel 0 is the icache by convention.
- ADDR_W, `XLEN, address width.
- DATA_W, 64, memory data width.
- TAG_W, 4, memory tag width; tag 0 means "no tag / rejected".
- FIXED_PRIO, 0, 0 = round-robin, 1 = fixed priority (lowest channel index wins).

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ch2ctrl_command  in  [NUM_CH][2]  per-channel BUS_NONE/BUS_LOAD/BUS_STORE; held until accepted.
- ch2ctrl_addr  in  [NUM_CH][ADDR_W]  per-channel request address.
- ch2ctrl_data  in  [NUM_CH][DATA_W]  per-channel store data.
- ctrl2ch_response  out  [NUM_CH][TAG_W]  accepted tag to the granted channel; 0 to all others.
- ctrl2ch_data  out  DATA_W  mem2proc_data broadcast to all channels.
- ctrl2ch_tag  out  [NUM_CH][TAG_W]  returning tag, routed only to the owning channel; 0 elsewhere.
- proc2mem_command  out  2  to mem.
- proc2mem_addr  out  ADDR_W  to mem.
- proc2mem_data  out  DATA_W  to mem.
- mem2proc_response  in  TAG_W  from mem; 0 means rejected.
- mem2proc_data  in  DATA_W  from mem.
- mem2proc_tag  in  TAG_W  from mem.
- outstanding_cnt  out  TAG_W+1  number of valid tag-table entries.
- stray_tag  out  1  one-cycle pulse: a nonzero mem2proc_tag arrived with no valid table entry.

Behaviour:
- Reset (reset_n=0, async):
  - Tag table cleared; RR pointer = 0; outstanding_cnt = 0; stray_tag = 0.
  - Combinational outputs follow inputs, but grant is forced to none, so proc2mem_command = BUS_NONE and all ctrl2ch_* are 0.
- Grant (combinational, same cycle):
  - Requesters = channels with command != BUS_NONE.
  - FIXED_PRIO=1: lowest requesting index wins.
  - FIXED_PRIO=0: first requester at or after the RR pointer, wrapping modulo NUM_CH.
  - No requester: proc2mem_command = BUS_NONE, addr/data = 0.
- Request path:
  - Granted channel's command/addr/data drive proc2mem_* directly.
  - ctrl2ch_response[g] = mem2proc_response; all other channels see 0 and keep holding their request.
- Acceptance = grant valid and mem2proc_response != 0. On acceptance:
  - RR pointer <= (g+1) mod NUM_CH. The pointer is unchanged on rejection or idle, so a rejected grant retries with the same winner.
  - If the command is BUS_LOAD: table[response] <= {valid=1, owner=g}.
  - Stores allocate nothing.
- Return path:
  - If mem2proc_tag != 0 and table[tag].valid: ctrl2ch_tag[owner] = mem2proc_tag, other channels 0; entry cleared next edge.
  - If mem2proc_tag != 0 and the entry is invalid: stray_tag <= 1 for one cycle; no channel sees the tag.
- Simultaneous allocate and retire of the same tag: the retire routes to the old owner; the new allocation is written and survives (allocate wins the write).
- outstanding_cnt:
  - +1 on load acceptance, -1 on valid retire; both in one cycle means net 0.
  - Never exceeds 2^TAG_W-1.
  - An acceptance whose tag is already valid is a memory-model protocol violation: assertion fires and the entry is overwritten.
- Reset mid-operation: all table entries are dropped. Tags returning afterwards raise stray_tag and are not routed.
- Latency: request and response are 0 cycles (combinational). Tag routing is 0 cycles from mem2proc_tag. Table update is visible from the next cycle.

Decomposition:
- sys_defs.svh:
  - BUS_COMMAND enum (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2).
  - MEM_TAG_W.
  - MEM_TAG_ENTRY struct {logic valid; logic [$clog2(NUM_CH_MAX)-1:0] owner;}.
  - NUM_CH_MAX = 8.
- Sub-module rr_arbiter (parametrised NUM_CH, FIXED_PRIO):
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant, grant index.
  - Holds the RR pointer.

Test Plan:
- NUM_CH=2, both LOAD every cycle, FIXED_PRIO=0, mem accepting all → grants alternate ch0, ch1, ch0...; each channel receives its own tags, e.g. ch0 tag 1, ch1 tag 2; ctrl2ch_tag never crosses channels.
- FIXED_PRIO=1, NUM_CH=4, ch1 and ch3 LOAD → ch1 wins until it drops, then ch3; ch3 sees response 0 while waiting.
- ch0 LOAD 0x40 accepted tag 5, then ch1 STORE 0x8040 accepted tag 6 → outstanding_cnt 1 (store not tracked); tag 5 returns with data 0xFFFF_1234_4321_FFFF → ctrl2ch_tag[0]=5, ctrl2ch_tag[1]=0, outstanding_cnt 0.
- mem rejects (response 0) for 3 cycles with ch0 and ch1 requesting → grant stays on the same channel, RR pointer unchanged; first acceptance then advances the pointer.
- Tag 3 retired and re-allocated to ch1 in the same cycle → old owner ch0 gets tag 3; table[3].owner=ch1; outstanding_cnt unchanged.
- Two loads outstanding, reset_n pulsed low mid-cycle → outputs 0 immediately; after release the returning tags raise stray_tag and no ctrl2ch_tag is driven.
